// File: rtl/fifo_pkg.sv
// Shared definitions for the ip_fifo write-side traffic generator and the
// read controller that sits on the other side of the FIFO.
package fifo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    HOLD  = ST_HOLD
  } wr_state_t;

  localparam int DATA_W_DEF = 8;

  // Also the read controller's FIFO_CNT_MAX, so both sides agree on burst size.
  localparam logic [7:0] BURST_MAX_DEF = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a synchronous clear that empties both
// stages, so no stale level survives a clear.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic d0;
  logic d1;

  // Two-stage resynchronisation; clear forces both stages low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      d0 <= din & ~clr;
      d1 <= d0 & ~clr;
    end
  end

  assign dout = d1;

endmodule

// File: rtl/fifo_wr.sv
// Write-side traffic generator: once the FIFO has drained (almost_empty seen
// in the write domain) it writes a burst of incrementing words, stopping on
// almost_full, full or the burst-length limit, then waits for almost_empty to
// drop before it can be triggered again.
module fifo_wr
  import fifo_pkg::*;
#(
  parameter int               DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] DATA_START = '0,
  parameter logic [DATA_W-1:0] DATA_STEP  = DATA_W'(1),
  parameter logic [7:0]        BURST_MAX  = BURST_MAX_DEF
) (
  input  logic              wr_clk,
  input  logic              sys_rst_n,
  input  logic              wr_rst_busy,
  input  logic              almost_empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              burst_done,
  output logic [7:0]        burst_cnt
);

  wr_state_t  state;
  logic [7:0] beat_cnt;
  logic       ae_sync;
  logic       accepted;
  logic       limit_hit;

  sync_2ff u_ae_sync (
    .clk   (wr_clk),
    .rst_n (sys_rst_n),
    .clr   (wr_rst_busy),
    .din   (almost_empty),
    .dout  (ae_sync)
  );

  // A write only counts when the FIFO actually takes it.
  assign accepted  = fifo_wr_en & ~full;
  assign limit_hit = accepted && ((beat_cnt + 8'd1) == BURST_MAX);

  // Burst FSM; every output is registered from the state being entered.
  always_ff @(posedge wr_clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= DATA_START;
      burst_done   <= 1'b0;
      burst_cnt    <= 8'd0;
      beat_cnt     <= 8'd0;
    end else if (wr_rst_busy) begin
      state      <= IDLE;
      fifo_wr_en <= 1'b0;
      burst_done <= 1'b0;
      beat_cnt   <= 8'd0;
    end else begin
      burst_done <= 1'b0;
      if (accepted) begin
        fifo_wr_data <= fifo_wr_data + DATA_STEP;
        beat_cnt     <= beat_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          fifo_wr_en <= 1'b0;
          beat_cnt   <= 8'd0;
          if (ae_sync && !full) begin
            state      <= WRITE;
            fifo_wr_en <= 1'b1;
          end
        end
        WRITE: begin
          if (almost_full || full || limit_hit) begin
            state      <= HOLD;
            fifo_wr_en <= 1'b0;
            burst_done <= 1'b1;
            burst_cnt  <= burst_cnt + 8'd1;
          end else begin
            fifo_wr_en <= 1'b1;
          end
        end
        HOLD: begin
          fifo_wr_en <= 1'b0;
          if (!ae_sync) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          fifo_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr.sv
// Directed bench for fifo_wr. Three instances share one set of inputs:
// a uses defaults, b has a 4-beat burst limit, c has a 4-beat limit and
// starts its data at 8'hFE. Each check compares {en, data, done, cnt}.
module tb_fifo_wr;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       ae;
  logic       af;
  logic       full;

  logic       a_en, b_en, c_en;
  logic [7:0] a_data, b_data, c_data;
  logic       a_done, b_done, c_done;
  logic [7:0] a_cnt, b_cnt, c_cnt;

  int checks;
  int errors;

  fifo_wr dut_a (
    .wr_clk       (clk),
    .sys_rst_n    (rst_n),
    .wr_rst_busy  (busy),
    .almost_empty (ae),
    .almost_full  (af),
    .full         (full),
    .fifo_wr_en   (a_en),
    .fifo_wr_data (a_data),
    .burst_done   (a_done),
    .burst_cnt    (a_cnt)
  );

  fifo_wr #(.BURST_MAX(8'd4)) dut_b (
    .wr_clk       (clk),
    .sys_rst_n    (rst_n),
    .wr_rst_busy  (busy),
    .almost_empty (ae),
    .almost_full  (af),
    .full         (full),
    .fifo_wr_en   (b_en),
    .fifo_wr_data (b_data),
    .burst_done   (b_done),
    .burst_cnt    (b_cnt)
  );

  fifo_wr #(.DATA_START(8'hFE), .DATA_STEP(8'd1), .BURST_MAX(8'd4)) dut_c (
    .wr_clk       (clk),
    .sys_rst_n    (rst_n),
    .wr_rst_busy  (busy),
    .almost_empty (ae),
    .almost_full  (af),
    .full         (full),
    .fifo_wr_en   (c_en),
    .fifo_wr_data (c_data),
    .burst_done   (c_done),
    .burst_cnt    (c_cnt)
  );

  // Free-running write clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    busy  = 1'b0;
    ae    = 1'b0;
    af    = 1'b0;
    full  = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_a: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b0, 8'h00, 1'b0, 8'h00});
    end
    checks++;
    if ({c_en, c_data, c_done, c_cnt} !== {1'b0, 8'hFE, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_c: got %h required %h", {c_en, c_data, c_done, c_cnt}, {1'b0, 8'hFE, 1'b0, 8'h00});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_latency();
    do_reset();
    ae = 1'b1;
    tick(2);
    checks++;
    if (a_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: en got %b required 0", a_en);
    end
    tick(1);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b1, 8'h00, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL latency_start: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b1, 8'h00, 1'b0, 8'h00});
    end
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      checks++;
      if ({a_en, a_data, a_done, a_cnt} !== {1'b1, 8'(i), 1'b0, 8'h00}) begin
        errors++;
        $display("[TB] FAIL data_incr_%0d: got %h required %h", i, {a_en, a_data, a_done, a_cnt}, {1'b1, 8'(i), 1'b0, 8'h00});
      end
    end
  endtask

  task automatic test_burst_limit();
    do_reset();
    ae = 1'b1;
    tick(3);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      checks++;
      if ({b_en, b_data, b_done, b_cnt} !== {1'b1, 8'(i), 1'b0, 8'h00}) begin
        errors++;
        $display("[TB] FAIL limit_beat_%0d: got %h required %h", i, {b_en, b_data, b_done, b_cnt}, {1'b1, 8'(i), 1'b0, 8'h00});
      end
    end
    tick(1);
    checks++;
    if ({b_en, b_data, b_done, b_cnt} !== {1'b0, 8'h04, 1'b1, 8'h01}) begin
      errors++;
      $display("[TB] FAIL limit_exit: got %h required %h", {b_en, b_data, b_done, b_cnt}, {1'b0, 8'h04, 1'b1, 8'h01});
    end
    tick(3);
    checks++;
    if ({b_en, b_data, b_done, b_cnt} !== {1'b0, 8'h04, 1'b0, 8'h01}) begin
      errors++;
      $display("[TB] FAIL limit_hold: got %h required %h", {b_en, b_data, b_done, b_cnt}, {1'b0, 8'h04, 1'b0, 8'h01});
    end
    ae = 1'b0;
    tick(3);
    ae = 1'b1;
    tick(2);
    checks++;
    if (b_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL retrigger_early: en got %b required 0", b_en);
    end
    tick(1);
    checks++;
    if ({b_en, b_data, b_done, b_cnt} !== {1'b1, 8'h04, 1'b0, 8'h01}) begin
      errors++;
      $display("[TB] FAIL retrigger_start: got %h required %h", {b_en, b_data, b_done, b_cnt}, {1'b1, 8'h04, 1'b0, 8'h01});
    end
  endtask

  // Continues from test_burst_limit: almost_full lands on the same edge as the limit.
  task automatic test_af_and_limit();
    tick(3);
    af = 1'b1;
    tick(1);
    checks++;
    if ({b_en, b_data, b_done, b_cnt} !== {1'b0, 8'h08, 1'b1, 8'h02}) begin
      errors++;
      $display("[TB] FAIL af_limit_exit: got %h required %h", {b_en, b_data, b_done, b_cnt}, {1'b0, 8'h08, 1'b1, 8'h02});
    end
    af = 1'b0;
    tick(1);
    checks++;
    if ({b_en, b_data, b_done, b_cnt} !== {1'b0, 8'h08, 1'b0, 8'h02}) begin
      errors++;
      $display("[TB] FAIL af_limit_after: got %h required %h", {b_en, b_data, b_done, b_cnt}, {1'b0, 8'h08, 1'b0, 8'h02});
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    ae = 1'b1;
    tick(3);
    tick(10);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b1, 8'd10, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL af_before: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b1, 8'd10, 1'b0, 8'h00});
    end
    af = 1'b1;
    tick(1);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b0, 8'd11, 1'b1, 8'h01}) begin
      errors++;
      $display("[TB] FAIL af_exit: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b0, 8'd11, 1'b1, 8'h01});
    end
    af = 1'b0;
    tick(4);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b0, 8'd11, 1'b0, 8'h01}) begin
      errors++;
      $display("[TB] FAIL af_hold: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b0, 8'd11, 1'b0, 8'h01});
    end
  endtask

  task automatic test_full();
    do_reset();
    ae = 1'b1;
    tick(3);
    tick(2);
    full = 1'b1;
    tick(1);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b0, 8'h02, 1'b1, 8'h01}) begin
      errors++;
      $display("[TB] FAIL full_exit: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b0, 8'h02, 1'b1, 8'h01});
    end
    tick(1);
    full = 1'b0;
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b0, 8'h02, 1'b0, 8'h01}) begin
      errors++;
      $display("[TB] FAIL full_second: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b0, 8'h02, 1'b0, 8'h01});
    end
  endtask

  task automatic test_wr_rst_busy();
    do_reset();
    ae = 1'b1;
    tick(3);
    tick(3);
    busy = 1'b1;
    tick(1);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b0, 8'h03, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL busy_abort: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b0, 8'h03, 1'b0, 8'h00});
    end
    tick(3);
    busy = 1'b0;
    tick(2);
    checks++;
    if (a_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_resync: en got %b required 0", a_en);
    end
    tick(1);
    checks++;
    if ({a_en, a_data, a_done, a_cnt} !== {1'b1, 8'h03, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL busy_restart: got %h required %h", {a_en, a_data, a_done, a_cnt}, {1'b1, 8'h03, 1'b0, 8'h00});
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'hFF;
    exp_data[1] = 8'h00;
    exp_data[2] = 8'h01;
    exp_data[3] = 8'h02;
    do_reset();
    ae = 1'b1;
    tick(3);
    checks++;
    if ({c_en, c_data, c_done, c_cnt} !== {1'b1, 8'hFE, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL wrap_start: got %h required %h", {c_en, c_data, c_done, c_cnt}, {1'b1, 8'hFE, 1'b0, 8'h00});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({c_en, c_data} !== {1'b1, exp_data[i]}) begin
        errors++;
        $display("[TB] FAIL wrap_beat_%0d: got %h required %h", i, {c_en, c_data}, {1'b1, exp_data[i]});
      end
    end
    tick(1);
    checks++;
    if ({c_en, c_data, c_done, c_cnt} !== {1'b0, exp_data[3], 1'b1, 8'h01}) begin
      errors++;
      $display("[TB] FAIL wrap_exit: got %h required %h", {c_en, c_data, c_done, c_cnt}, {1'b0, exp_data[3], 1'b1, 8'h01});
    end
    ae = 1'b0;
    tick(3);
    ae = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({c_en, c_data, c_done, c_cnt} !== {1'b0, 8'hFE, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL midburst_reset: got %h required %h", {c_en, c_data, c_done, c_cnt}, {1'b0, 8'hFE, 1'b0, 8'h00});
    end
    rst_n = 1'b1;
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start_latency();
    test_burst_limit();
    test_af_and_limit();
    test_almost_full();
    test_full();
    test_wr_rst_busy();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
